selection_aco_seq: RTL

Registered, parametrised output-port selection unit for the adaptive NoC router. It holds a per-destination pheromone table in flops and advances a per-input LFSR. Each cycle it picks one output port per input from that input's routing-candidate list. Four modes are supported: first-candidate, random, OBL (most credits) and ACO (pheromone-driven with random fallback). Reward updates are arbitrated per table row, and a periodic evaporation step pulls every entry back toward its initial value.

---
 rtl/selection_aco_seq_if.sv | 36 +++
 rtl/selection_aco_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/selection_aco_seq_if.sv
// Port bundle of the ACO output-selection unit: per-input selection and
// reward requests in, registered selections, drops and table view out.
interface selection_aco_seq_if #(
  parameter int N     = 5,
  parameter int M     = 4,
  parameter int XW    = 2,
  parameter int YW    = 2,
  parameter int NODES = 16,
  parameter int DW    = 4,
  parameter int PH_W  = 4
);
  logic [N-1:0][3:0]                 i_en;
  logic [N-1:0]                      i_select_neighbor;
  logic [N-1:0][M-1:0][1:0]          i_avail_directions;
  logic [N-1:0][XW-1:0]              i_x_dest;
  logic [N-1:0][YW-1:0]              i_y_dest;
  logic [N-1:0]                      i_update;
  logic [N-1:0][DW-1:0]              i_update_dest;
  logic [N-1:0][1:0]                 i_update_code;
  logic [N-1:0][N-1:0]               o_output_req;
  logic [N-1:0]                      o_req_valid;
  logic [N-1:0]                      o_update_drop;
  logic [NODES-1:0][N-2:0][PH_W-1:0] o_pheromones;

  modport master (
    output i_en, i_select_neighbor, i_avail_directions, i_x_dest, i_y_dest,
    output i_update, i_update_dest, i_update_code,
    input  o_output_req, o_req_valid, o_update_drop, o_pheromones
  );

  modport slave (
    input  i_en, i_select_neighbor, i_avail_directions, i_x_dest, i_y_dest,
    input  i_update, i_update_dest, i_update_code,
    output o_output_req, o_req_valid, o_update_drop, o_pheromones
  );
endinterface

// File: rtl/selection_aco_seq.sv
// Registered output-port selector for the adaptive NoC router: first / random /
// most-credit / pheromone-driven choice per input, with reward and evaporation.
module selection_aco_seq #(
  parameter int X_LOC        = 0,
  parameter int Y_LOC        = 0,
  parameter int X_NODES      = 4,
  parameter int Y_NODES      = 4,
  parameter int N            = 5,
  parameter int M            = 4,
  parameter int PH_W         = 4,
  parameter int PH_INIT      = 8,
  parameter int PH_MAX       = 15,
  parameter int PH_MIN       = 0,
  parameter int PH_DELTA     = 2,
  parameter int THRESH       = 10,
  parameter int DECAY_PERIOD = 256,
  parameter int MODE         = 3
) (
  input logic                clk,
  input logic                reset_n,
  selection_aco_seq_if.slave bus
);
  localparam int NODES = X_NODES * Y_NODES;
  localparam int DW    = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int L     = M - 1;
  localparam int IW    = (M > 1) ? $clog2(M) : 1;
  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

  generate
    if (X_LOC >= X_NODES || Y_LOC >= Y_NODES) begin : g_bad_loc
      $error("selection_aco_seq: router location lies outside the mesh");
    end
  endgenerate

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [PH_W-1:0] sat_inc(input logic [PH_W-1:0] v);
    return (int'(v) + PH_DELTA > PH_MAX) ? PH_W'(PH_MAX) : PH_W'(int'(v) + PH_DELTA);
  endfunction

  function automatic logic [PH_W-1:0] sat_dec(input logic [PH_W-1:0] v);
    return (int'(v) - 1 < PH_MIN) ? PH_W'(PH_MIN) : PH_W'(int'(v) - 1);
  endfunction

  function automatic logic [PH_W-1:0] evaporate(input logic [PH_W-1:0] v);
    if (int'(v) > PH_INIT) return PH_W'(int'(v) - 1);
    if (int'(v) < PH_INIT) return PH_W'(int'(v) + 1);
    return v;
  endfunction

  logic [N-1:0][7:0]                 lfsr_reg;
  logic [NODES-1:0][N-2:0][PH_W-1:0] table_reg, table_next;
  logic [CW-1:0]                     decay_reg, decay_next;
  logic                              wrap;
  logic [N-1:0][N-1:0]               req_reg, req_next;
  logic [N-1:0]                      valid_reg, drop_reg, drop_next, accept;

  always_comb begin
    wrap       = 1'b0;
    decay_next = '0;
    if (DECAY_PERIOD > 0) begin
      wrap       = (int'(decay_reg) == DECAY_PERIOD - 1);
      decay_next = wrap ? '0 : decay_reg + CW'(1);
    end
  end

  // Per-input selection; every comparison reads the table as registered before this edge.
  for (genvar gi = 0; gi < N; gi++) begin : g_sel
    logic [1:0]      cnt, cnt_div, code, first_code, rnd_code, obl_code, aco_code, pick_code;
    logic [IW-1:0]   rnd;
    logic [DW-1:0]   row;
    logic [PW-1:0]   port;
    logic [3:0]      best_en;
    logic [PH_W-1:0] ph, ph_max, ph_min;
    logic [PH_W:0]   spread;
    logic            list_ok, any_ok, pick_ok;
    logic [N-1:0]    req_l;

    always_comb begin
      cnt        = bus.i_avail_directions[gi][M-1];
      cnt_div    = (cnt == 2'd0) ? 2'd1 : cnt;
      list_ok    = (cnt != 2'd0) && (int'(cnt) <= L);
      rnd        = IW'(lfsr_reg[gi] % {6'd0, cnt_div});
      first_code = bus.i_avail_directions[gi][0];
      rnd_code   = bus.i_avail_directions[gi][rnd];
      row        = DW'(int'(bus.i_y_dest[gi]) * X_NODES + int'(bus.i_x_dest[gi]));
      any_ok     = 1'b0;
      obl_code   = '0;
      aco_code   = '0;
      best_en    = '0;
      ph_max     = '0;
      ph_min     = '0;
      code       = '0;
      port       = '0;
      ph         = '0;
      for (int k = 0; k < L; k++) begin
        code = bus.i_avail_directions[gi][IW'(k)];
        port = PW'(int'(code) + 1);
        ph   = table_reg[row][code];
        // U-turn back to the requesting port is never a comparison candidate.
        if (k < int'(cnt) && int'(port) != gi && int'(code) < N - 1) begin
          if (!any_ok || bus.i_en[port] > best_en) begin
            best_en  = bus.i_en[port];
            obl_code = code;
          end
          if (!any_ok || ph > ph_max) begin
            ph_max   = ph;
            aco_code = code;
          end
          if (!any_ok || ph < ph_min) ph_min = ph;
          any_ok = 1'b1;
        end
      end

      spread    = {1'b0, ph_max} - {1'b0, ph_min};
      pick_ok   = 1'b1;
      pick_code = first_code;
      case (MODE)
        0: pick_code = first_code;
        1: pick_code = rnd_code;
        2: begin
          pick_code = obl_code;
          pick_ok   = any_ok;
        end
        default: begin
          pick_code = (spread > (PH_W+1)'(THRESH)) ? aco_code : rnd_code;
          pick_ok   = any_ok;
        end
      endcase

      req_l = '0;
      if (bus.i_select_neighbor[gi] && list_ok && pick_ok)
        req_l = N'(1) << (int'(pick_code) + 1);
    end

    assign req_next[gi] = req_l;
  end

  // Only the lowest-indexed updater of a row wins this cycle.
  for (genvar gi = 0; gi < N; gi++) begin : g_arb
    logic beaten;

    always_comb begin
      beaten = 1'b0;
      for (int j = 0; j < gi; j++)
        if (bus.i_update[j] && bus.i_update_dest[j] == bus.i_update_dest[gi]) beaten = 1'b1;
    end

    assign accept[gi]    = bus.i_update[gi] && !beaten;
    assign drop_next[gi] = bus.i_update[gi] && beaten;
  end

  for (genvar gi = 0; gi < NODES; gi++) begin : g_row
    logic       hit;
    logic [1:0] hit_code;

    always_comb begin
      hit      = 1'b0;
      hit_code = '0;
      for (int j = 0; j < N; j++)
        if (accept[j] && int'(bus.i_update_dest[j]) == gi) begin
          hit      = 1'b1;
          hit_code = bus.i_update_code[j];
        end
    end

    // A rewarded row skips evaporation on a wrap cycle.
    for (genvar gj = 0; gj < N - 1; gj++) begin : g_col
      assign table_next[gi][gj] =
        hit  ? ((int'(hit_code) == gj) ? sat_inc(table_reg[gi][gj]) : sat_dec(table_reg[gi][gj])) :
        wrap ? evaporate(table_reg[gi][gj]) : table_reg[gi][gj];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) lfsr_reg[i] <= 8'(i * 37 + 1);
      for (int r = 0; r < NODES; r++)
        for (int c = 0; c < N - 1; c++) table_reg[r][c] <= PH_W'(PH_INIT);
      decay_reg <= '0;
      req_reg   <= '0;
      valid_reg <= '0;
      drop_reg  <= '0;
    end else begin
      for (int i = 0; i < N; i++) lfsr_reg[i] <= lfsr_step(lfsr_reg[i]);
      table_reg <= table_next;
      decay_reg <= decay_next;
      req_reg   <= req_next;
      valid_reg <= bus.i_select_neighbor;
      drop_reg  <= drop_next;
    end
  end

  assign bus.o_output_req  = req_reg;
  assign bus.o_req_valid   = valid_reg;
  assign bus.o_update_drop = drop_reg;
  assign bus.o_pheromones  = table_reg;
endmodule
